// File: rtl/rng_lfsr_seq.sv
// Random value source for the memory game: button-timing entropy reseeds a Galois LFSR.
// Optional RNG_NO_REPEAT_EN: re-steps the LFSR until the value differs from the last one delivered.
module rng_lfsr_seq #(
  parameter int unsigned       WIDTH       = 4,
  parameter int unsigned       LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] TAPS        = 16'hB400,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             button,
  input  logic             req,
  output logic [WIDTH-1:0] num_out,
  output logic             num_valid,
  output logic             seeded,
  output logic             busy
);

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    READY    = 2'd1,
    BUSY     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_prev_q;
  logic                   press_c;
  logic [LFSR_W-1:0]      cnt_q;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]      step_c;
  logic [LFSR_W-1:0]      seed_c;
  logic [WIDTH-1:0]       value_c;
  logic [WIDTH-1:0]       num_out_d;
  logic                   num_valid_d, seeded_d, busy_d;
  logic                   deliver_c;
`ifdef RNG_NO_REPEAT_EN
  logic                   prev_valid_q, prev_valid_d;
`endif

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Chain idles at 1 (button released); a press is the first synchronised low sample.
  assign press_c = btn_prev_q & ~sync_q[SYNC_STAGES-1];
  assign step_c  = lfsr_step(lfsr_q);
  assign value_c = step_c[LFSR_W-1 -: WIDTH];
  assign seed_c  = lfsr_q ^ cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_q     <= '1;
      btn_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], button};
      btn_prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q      <= cnt_q + LFSR_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= UNSEEDED;
      lfsr_q       <= '0;
      num_out      <= '0;
      num_valid    <= 1'b0;
      seeded       <= 1'b0;
      busy         <= 1'b0;
`ifdef RNG_NO_REPEAT_EN
      prev_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      num_out      <= num_out_d;
      num_valid    <= num_valid_d;
      seeded       <= seeded_d;
      busy         <= busy_d;
`ifdef RNG_NO_REPEAT_EN
      prev_valid_q <= prev_valid_d;
`endif
    end
  end

  // Next state; a press overrides any request, including one already in flight.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    num_out_d   = num_out;
    num_valid_d = 1'b0;
    seeded_d    = seeded;
    busy_d      = busy;
    deliver_c   = 1'b0;
`ifdef RNG_NO_REPEAT_EN
    prev_valid_d = prev_valid_q;
`endif

    if (press_c) begin
      lfsr_d   = (seed_c == '0) ? LFSR_W'(1) : seed_c;
      seeded_d = 1'b1;
      busy_d   = 1'b0;
      state_d  = READY;
`ifdef RNG_NO_REPEAT_EN
      prev_valid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        READY: begin
          if (req) begin
            lfsr_d  = step_c;
            busy_d  = 1'b1;
            state_d = BUSY;
`ifdef RNG_NO_REPEAT_EN
            deliver_c = !(prev_valid_q && (value_c == num_out));
`else
            deliver_c = 1'b1;
`endif
          end
        end
        BUSY: begin
`ifdef RNG_NO_REPEAT_EN
          // Strobe seen last cycle means done; otherwise keep stepping past the repeat.
          if (num_valid) begin
            busy_d  = 1'b0;
            state_d = READY;
          end else begin
            lfsr_d    = step_c;
            deliver_c = (value_c != num_out);
          end
`else
          busy_d  = 1'b0;
          state_d = READY;
`endif
        end
        default: ;
      endcase
    end

    if (deliver_c) begin
      num_out_d   = value_c;
      num_valid_d = 1'b1;
`ifdef RNG_NO_REPEAT_EN
      prev_valid_d = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_rng_lfsr_seq.sv
// Scoreboard bench for rng_lfsr_seq: directed presses timed against the free-running counter.
module tb_rng_lfsr_seq;

  logic       Clk;
  logic       Rst;
  logic       button;
  logic       req;
  logic [3:0] num_out;
  logic       num_valid;
  logic       seeded;
  logic       busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tb_cnt;

  typedef struct {
    logic [3:0]  val;
    int unsigned due;
  } exp_t;

  exp_t q[$];

  rng_lfsr_seq dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .button   (button),
    .req      (req),
    .num_out  (num_out),
    .num_valid(num_valid),
    .seeded   (seeded),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference copy of the DUT's free-running counter (value during the current cycle).
  always @(posedge Clk or posedge Rst) begin
    if (Rst) tb_cnt <= 0;
    else     tb_cnt <= tb_cnt + 1;
  end

  // Monitor: every strobe must match the oldest expectation, in the expected cycle.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (num_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: num_out=%h at cnt=%0d, nothing expected", num_out, tb_cnt);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (num_out !== e.val || tb_cnt != e.due || busy !== 1'b1) begin
            errors++;
            $display("FAIL result: num_out=%h cnt=%0d busy=%b, required %h at cnt=%0d busy=1",
                     num_out, tb_cnt, busy, e.val, e.due);
          end
        end
      end else if (q.size() != 0 && tb_cnt > q[0].due) begin
        checks++;
        errors++;
        $display("FAIL timeout: no num_valid by cnt=%0d, required %h at cnt=%0d", tb_cnt, q[0].val, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Advance to the cycle whose counter value is 'target', sampling 1 time unit after the edge.
  task automatic wait_cnt(input int unsigned target);
    int unsigned n;
    n = 0;
    while (tb_cnt != target) begin
      @(posedge Clk);
      #1;
      n++;
      if (n > 20000) begin
        $display("FAIL wait_cnt: counter %0d never reached %0d", tb_cnt, target);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  // Button low early enough that the synchronised press lands in cycle 'target'.
  task automatic press(input int unsigned target, input int unsigned hold);
    wait_cnt(target - 2);
    button = 1'b0;
    wait_cnt(target + hold);
    button = 1'b1;
  endtask

  task automatic do_req(input logic [3:0] val);
    exp_t e;
    wait_cnt(tb_cnt + 1);
    req   = 1'b1;
    e.val = val;
    e.due = tb_cnt + 1;
    q.push_back(e);
    wait_cnt(tb_cnt + 1);
    req = 1'b0;
  endtask

  initial begin
    Rst    = 1'b1;
    button = 1'b1;
    req    = 1'b0;
    #22 Rst = 1'b0;
    #1;
    check("reset_seeded", 32'(seeded), 0);
    check("reset_num_out", 32'(num_out), 0);
    check("reset_num_valid", 32'(num_valid), 0);
    check("reset_busy", 32'(busy), 0);

    // Requests before any press are ignored.
    for (int i = 0; i < 3; i++) begin
      wait_cnt(tb_cnt + 2);
      req = 1'b1;
      wait_cnt(tb_cnt + 1);
      req = 1'b0;
    end
    wait_cnt(tb_cnt + 3);
    check("unseeded_seeded", 32'(seeded), 0);
    check("unseeded_num_out", 32'(num_out), 0);
    check("unseeded_busy", 32'(busy), 0);

    // Seeds 0x10, ^0x20, ^0x31 leave lfsr = 0x0001.
    press(32'h10, 0);
    wait_cnt(32'h12);
    check("seeded_after_press", 32'(seeded), 1);
    check("busy_after_press", 32'(busy), 0);
    press(32'h20, 0);
    press(32'h31, 0);
    do_req(4'hB);
    do_req(4'h5);
    do_req(4'h2);
    do_req(4'h1);

    // lfsr = 0x1680; press at cnt 0x1680 hits the zero guard, with a colliding req.
    wait_cnt(32'h1680 - 2);
    button = 1'b0;
    wait_cnt(32'h1680);
    req = 1'b1;
    wait_cnt(32'h1681);
    req    = 1'b0;
    button = 1'b1;
    check("collide_busy", 32'(busy), 0);
    check("collide_num_valid", 32'(num_valid), 0);
    check("collide_seeded", 32'(seeded), 1);
    do_req(4'hB);

    // Bounce: three short presses xor 0x1700, 0x1705, 0x170A into 0xB400 -> 0xA30F.
    press(32'h1700, 0);
    press(32'h1705, 0);
    press(32'h170A, 0);
    wait_cnt(32'h1712);
    do_req(4'hE);

    // lfsr = 0xE587; one long hold at 0x1780 -> 0xF207, release adds nothing.
    press(32'h1780, 100);
    wait_cnt(32'h17F0);
    check("hold_busy", 32'(busy), 0);
    do_req(4'hC);

    // Reset while busy clears outputs at once; nothing follows after release.
    begin
      exp_t e;
      wait_cnt(tb_cnt + 1);
      req   = 1'b1;
      e.val = 4'hD;
      e.due = tb_cnt + 1;
      q.push_back(e);
      wait_cnt(tb_cnt + 1);
      req = 1'b0;
    end
    @(negedge Clk);
    #1;
    check("pre_reset_busy", 32'(busy), 1);
    Rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_num_out", 32'(num_out), 0);
    check("midrst_num_valid", 32'(num_valid), 0);
    check("midrst_seeded", 32'(seeded), 0);
    #20 Rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      wait_cnt(tb_cnt + 2);
      req = 1'b1;
      wait_cnt(tb_cnt + 1);
      req = 1'b0;
    end
    wait_cnt(tb_cnt + 5);
    check("post_reset_seeded", 32'(seeded), 0);
    check("post_reset_num_out", 32'(num_out), 0);
    check("pending_expectations", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
